// File: rtl/ssm_tile_scheduler.sv
// Issues (head, p-tile) work items to the shared SSM engine and tracks
// in-order completions for one token.
//   state | meaning
//   IDLE  | waiting for start; counters hold last token's result
//   ISSUE | offering items head-major, up to MAX_OUT in flight
//   DRAIN | every item issued, waiting for the remaining completions
//   DONE  | one-cycle token-done pulse
module ssm_tile_scheduler #(
  parameter int H       = 4,
  parameter int P       = 4,
  parameter int PT      = 2,
  parameter int MAX_OUT = 2,
  parameter int HW      = (H > 1) ? $clog2(H) : 1,
  parameter int TW      = ((P / PT) > 1) ? $clog2(P / PT) : 1,
  localparam int NPT    = P / PT,
  localparam int NT     = H * NPT,
  localparam int CW     = $clog2(NT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          eng_start,
  input  logic          eng_ready,
  output logic [HW-1:0] eng_head,
  output logic [TW-1:0] eng_ptile,
  input  logic          eng_done,
  output logic          head_done,
  output logic [HW-1:0] head_done_idx,
  output logic          busy,
  output logic [CW-1:0] tiles_done,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam int IW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] LAST_ITEM = CW'(NT - 1);
  localparam logic [IW-1:0] MAX_C     = IW'(MAX_OUT);
  localparam logic [TW-1:0] LAST_T    = TW'(NPT - 1);
  localparam logic [HW-1:0] LAST_H    = HW'(H - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] issued, completed;
  logic [IW-1:0] inflight;
  logic [HW-1:0] head_q, done_head;
  logic [TW-1:0] ptile_q, done_ptile;
  logic          active, xfer, done_ok;

  assign active  = (state == S_ISSUE) || (state == S_DRAIN);
  assign xfer    = eng_start && eng_ready;
  // a completion only counts against an item actually in flight
  assign done_ok = eng_done && active && (inflight != '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: if (xfer && issued == LAST_ITEM) state_nxt = S_DRAIN;
      S_DRAIN: if (done_ok && completed == LAST_ITEM) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    eng_start = (state == S_ISSUE) && (inflight < MAX_C) && (issued <= LAST_ITEM);
    busy      = active;
    done      = (state == S_DONE);
  end

  assign eng_head   = head_q;
  assign eng_ptile  = ptile_q;
  assign tiles_done = completed;

  always_ff @(posedge clk) begin
    if (rst) begin
      issued        <= '0;
      completed     <= '0;
      inflight      <= '0;
      head_q        <= '0;
      ptile_q       <= '0;
      done_head     <= '0;
      done_ptile    <= '0;
      head_done     <= 1'b0;
      head_done_idx <= '0;
      err           <= 1'b0;
    end else begin
      head_done <= 1'b0;
      if (state == S_IDLE && start) begin
        issued     <= '0;
        completed  <= '0;
        inflight   <= '0;
        head_q     <= '0;
        ptile_q    <= '0;
        done_head  <= '0;
        done_ptile <= '0;
      end else begin
        if (xfer) begin
          issued <= issued + 1'b1;
          if (ptile_q == LAST_T) begin
            ptile_q <= '0;
            head_q  <= (head_q == LAST_H) ? '0 : head_q + 1'b1;
          end else begin
            ptile_q <= ptile_q + 1'b1;
          end
        end
        if (done_ok) begin
          completed <= completed + 1'b1;
          if (done_ptile == LAST_T) begin
            done_ptile    <= '0;
            done_head     <= (done_head == LAST_H) ? '0 : done_head + 1'b1;
            head_done     <= 1'b1;
            head_done_idx <= done_head;
          end else begin
            done_ptile <= done_ptile + 1'b1;
          end
        end
        case ({xfer, done_ok})
          2'b10:   inflight <= inflight + 1'b1;
          2'b01:   inflight <= inflight - 1'b1;
          default: inflight <= inflight;
        endcase
      end
      if (eng_done && !done_ok) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ssm_tile_scheduler.sv
// Randomized engine model driving ssm_tile_scheduler; checks every cycle
// against a counting reference model of the token schedule.
module tb_ssm_tile_scheduler;

  localparam int H = 4, P = 4, PT = 2, MAX_OUT = 2;
  localparam int NPT = P / PT, NT = H * NPT;
  localparam int HW = 2, TW = 1, CW = 4;

  logic          clk = 1'b0;
  logic          rst, start, eng_ready, eng_done;
  logic          eng_start, head_done, busy, done, err;
  logic [HW-1:0] eng_head, head_done_idx;
  logic [TW-1:0] eng_ptile;
  logic [CW-1:0] tiles_done;

  always #5 clk = ~clk;

  ssm_tile_scheduler #(.H(H), .P(P), .PT(PT), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .eng_start(eng_start), .eng_ready(eng_ready),
    .eng_head(eng_head), .eng_ptile(eng_ptile), .eng_done(eng_done),
    .head_done(head_done), .head_done_idx(head_done_idx),
    .busy(busy), .tiles_done(tiles_done), .done(done), .err(err)
  );

  int n_vec = 0, n_err = 0, cyc = 0;
  bit m_active = 0, m_done_cyc = 0, m_err = 0, m_hd = 0;
  int m_issued = 0, m_completed = 0, m_hd_idx = 0, last_due = 0;
  int due_q[$];
  int lat_min = 3, lat_max = 3, ready_pct = 100, hold_item = -1, hold_cnt = 0;
  bit start_spam = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: check outputs, drive inputs, advance the model, cross the edge.
  task automatic tick(input bit s, input bit r, input bit spur);
    bit exp_start, xfer, dv, was_done;
    int d;
    exp_start = m_active && (m_issued < NT) && ((m_issued - m_completed) < MAX_OUT);
    chk("eng_start", eng_start, exp_start);
    chk("busy", busy, m_active);
    chk("done", done, m_done_cyc);
    chk("tiles_done", tiles_done, m_completed);
    chk("err", err, m_err);
    chk("head_done", head_done, m_hd);
    if (m_hd) chk("head_done_idx", head_done_idx, m_hd_idx);
    if (exp_start) begin
      chk("eng_head", eng_head, m_issued / NPT);
      chk("eng_ptile", eng_ptile, m_issued % NPT);
    end

    rst   = r;
    start = s;
    if (hold_item == m_issued && exp_start && hold_cnt < 5) begin
      eng_ready = 1'b0;
      hold_cnt++;
    end else begin
      eng_ready = (int'($urandom_range(0, 99)) < ready_pct);
    end
    eng_done = spur || (due_q.size() > 0 && due_q[0] == cyc);
    xfer = exp_start && eng_ready;
    dv   = eng_done && m_active && (m_issued > m_completed);

    if (due_q.size() > 0 && due_q[0] == cyc) void'(due_q.pop_front());
    if (xfer) begin
      d = cyc + int'($urandom_range(lat_min, lat_max));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      due_q.push_back(d);
    end

    was_done = m_done_cyc;
    m_hd = 1'b0;
    if (r) begin
      m_active = 0; m_done_cyc = 0; m_err = 0;
      m_issued = 0; m_completed = 0;
      due_q.delete();
      last_due = cyc;
    end else begin
      m_done_cyc = 0;
      if (dv) begin
        if (m_completed % NPT == NPT - 1) begin
          m_hd = 1'b1;
          m_hd_idx = m_completed / NPT;
        end
        m_completed++;
      end else if (eng_done) begin
        m_err = 1'b1;
      end
      if (xfer) m_issued++;
      if (dv && m_completed == NT) begin
        m_active = 0;
        m_done_cyc = 1;
      end else if (s && !m_active && !was_done) begin
        m_active = 1;
        m_issued = 0;
        m_completed = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_token();
    int n;
    tick(1'b1, 1'b0, 1'b0);
    n = 0;
    while (!m_done_cyc && n < 500) begin
      tick(start_spam ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("token_timeout", (n < 500), 1);
    tick(start_spam ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; eng_ready = 1'b0; eng_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tick(1'b0, 1'b0, 1'b0);

    // steady pipeline, fixed 3-cycle engine
    lat_min = 3; lat_max = 3; ready_pct = 100;
    run_token();

    // back-pressure on item (1,1)
    hold_item = 3; hold_cnt = 0;
    run_token();
    hold_item = -1;
    chk("hold_cycles", hold_cnt, 5);

    // latency 2 forces issue and completion in the same cycle
    lat_min = 2; lat_max = 2;
    run_token();

    // spurious completion while idle
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    lat_min = 3; lat_max = 3;
    run_token();

    // reset in the middle of issuing
    tick(1'b1, 1'b0, 1'b0);
    n = 0;
    while (m_issued < 3 && n < 50) begin
      tick(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("pre_rst_issued", (m_issued == 3), 1);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    run_token();

    // start spam during the token
    start_spam = 1; ready_pct = 70; lat_min = 1; lat_max = 5;
    run_token();

    repeat (8) begin
      lat_min    = int'($urandom_range(1, 3));
      lat_max    = lat_min + int'($urandom_range(0, 5));
      ready_pct  = int'($urandom_range(30, 100));
      start_spam = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      run_token();
    end
    start_spam = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
